// File: rtl/framebuffer_write_scheduler_pkg.sv
// Shared types and screen constants for the framebuffer write scheduler.
// The AXIS state is only reachable when FB_SCHED_AXIS_EN is defined.
package fb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    AXIS  = 2'd2,
    PLOT  = 2'd3
  } fb_sched_state_t;

  localparam int FB_SCREEN_WIDTH  = 640;
  localparam int FB_SCREEN_HEIGHT = 480;

  function automatic int fb_num_pixels(input int width, input int height);
    return width * height;
  endfunction

  // First pixel of the horizontal centre line.
  function automatic int fb_axis_base(input int width, input int height);
    return (height / 2) * width;
  endfunction

  localparam int FB_NUM_PIXELS = fb_num_pixels(FB_SCREEN_WIDTH, FB_SCREEN_HEIGHT);
  localparam int FB_AXIS_BASE  = fb_axis_base(FB_SCREEN_WIDTH, FB_SCREEN_HEIGHT);
  localparam int FB_ADDR_WIDTH = $clog2(FB_NUM_PIXELS);

endpackage

// File: rtl/framebuffer_write_scheduler_if.sv
// Plotter handshake plus framebuffer write port; the scheduler takes the slave side.
interface fb_sched_if
  import fb_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH
);
  logic                  plot_valid;
  logic [ADDR_WIDTH-1:0] plot_addr;
  logic                  plot_data;
  logic                  plot_ready;
  logic                  fb_wr_en;
  logic [ADDR_WIDTH-1:0] fb_wr_addr;
  logic                  fb_wr_data;

  modport slave (
    input  plot_valid, plot_addr, plot_data,
    output plot_ready, fb_wr_en, fb_wr_addr, fb_wr_data
  );

  modport master (
    output plot_valid, plot_addr, plot_data,
    input  plot_ready, fb_wr_en, fb_wr_addr, fb_wr_data
  );
endinterface

// File: rtl/framebuffer_write_scheduler_sweeper.sv
// Walks base..base+length-1, one address per cycle. The address is valid in the
// start cycle itself so the caller can register it with one cycle of latency.
module fb_address_sweeper #(
  parameter int ADDR_WIDTH = 19,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  logic                  active_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  offset_reg;

  logic                  running;
  logic [ADDR_WIDTH-1:0] cur_base;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [LEN_WIDTH-1:0]  cur_off;

  assign running  = start | active_reg;
  assign cur_base = start ? base : base_reg;
  assign cur_len  = start ? length : len_reg;
  assign cur_off  = start ? '0 : offset_reg;
  assign addr     = cur_base + cur_off[ADDR_WIDTH-1:0];
  assign last     = running && (cur_off == cur_len - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg <= 1'b0;
      base_reg   <= '0;
      len_reg    <= '0;
      offset_reg <= '0;
    end else if (running) begin
      base_reg <= cur_base;
      len_reg  <= cur_len;
      if (last) begin
        active_reg <= 1'b0;
        offset_reg <= '0;
      end else begin
        active_reg <= 1'b1;
        offset_reg <= cur_off + LEN_WIDTH'(1);
      end
    end
  end
endmodule

// File: rtl/framebuffer_write_scheduler.sv
// Per-frame framebuffer port owner: clear sweep, optional centre line
// (FB_SCHED_AXIS_EN), then plotter writes via valid/ready.
module framebuffer_write_scheduler
  import fb_sched_pkg::*;
#(
  parameter int SCREEN_WIDTH  = FB_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = FB_SCREEN_HEIGHT,
  parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     frame_pulse,
  fb_sched_if.slave bus,
  output logic     busy,
  output logic     frame_overrun
);
  localparam int NUM_PIXELS = fb_num_pixels(SCREEN_WIDTH, SCREEN_HEIGHT);
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
`ifdef FB_SCHED_AXIS_EN
  localparam logic [ADDR_WIDTH-1:0] AXIS_BASE =
    ADDR_WIDTH'(fb_axis_base(SCREEN_WIDTH, SCREEN_HEIGHT));
`endif

  fb_sched_state_t       state_reg;
  logic                  pending_reg;
  logic                  sweep_done_reg;
  logic                  plot_ready_reg;
  logic                  fb_wr_en_reg;
  logic [ADDR_WIDTH-1:0] fb_wr_addr_reg;
  logic                  fb_wr_data_reg;
  logic                  busy_reg;
  logic                  overrun_reg;

  logic                  beat;
  logic                  sweep_start;
  logic                  sweep_last;
  logic [ADDR_WIDTH-1:0] sweep_base;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [LEN_WIDTH-1:0]  sweep_len;

  assign beat = bus.plot_valid & plot_ready_reg;

  // A frame pulse that coincides with an accepted beat defers the clear by one cycle.
  always_comb begin
    sweep_start = 1'b0;
    sweep_base  = '0;
    sweep_len   = LEN_WIDTH'(NUM_PIXELS);
    unique case (state_reg)
      IDLE: sweep_start = frame_pulse;
      PLOT: sweep_start = pending_reg | (frame_pulse & ~beat);
`ifdef FB_SCHED_AXIS_EN
      CLEAR: begin
        sweep_start = sweep_done_reg;
        sweep_base  = AXIS_BASE;
        sweep_len   = LEN_WIDTH'(SCREEN_WIDTH);
      end
`endif
      default: ;
    endcase
  end

  fb_address_sweeper #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_sweeper (
    .clk   (clk),
    .reset (reset),
    .start (sweep_start),
    .base  (sweep_base),
    .length(sweep_len),
    .addr  (sweep_addr),
    .last  (sweep_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pending_reg    <= 1'b0;
      sweep_done_reg <= 1'b0;
      plot_ready_reg <= 1'b0;
      fb_wr_en_reg   <= 1'b0;
      fb_wr_addr_reg <= '0;
      fb_wr_data_reg <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      sweep_done_reg <= sweep_last;
      fb_wr_en_reg   <= 1'b0;
      overrun_reg    <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (sweep_start) begin
            state_reg      <= CLEAR;
            busy_reg       <= 1'b1;
            fb_wr_en_reg   <= 1'b1;
            fb_wr_addr_reg <= sweep_addr;
            fb_wr_data_reg <= 1'b0;
          end
        end
        PLOT: begin
          if (beat) begin
            fb_wr_en_reg   <= 1'b1;
            fb_wr_addr_reg <= bus.plot_addr;
            fb_wr_data_reg <= bus.plot_data;
          end
          if (sweep_start) begin
            state_reg      <= CLEAR;
            pending_reg    <= 1'b0;
            plot_ready_reg <= 1'b0;
            busy_reg       <= 1'b1;
            fb_wr_en_reg   <= 1'b1;
            fb_wr_addr_reg <= sweep_addr;
            fb_wr_data_reg <= 1'b0;
          end else if (frame_pulse) begin
            plot_ready_reg <= 1'b0;
            pending_reg    <= 1'b1;
          end
        end
        CLEAR: begin
          overrun_reg <= frame_pulse;
          if (sweep_done_reg) begin
`ifdef FB_SCHED_AXIS_EN
            state_reg      <= AXIS;
            fb_wr_en_reg   <= 1'b1;
            fb_wr_addr_reg <= sweep_addr;
            fb_wr_data_reg <= 1'b1;
`else
            state_reg      <= PLOT;
            busy_reg       <= 1'b0;
            plot_ready_reg <= 1'b1;
`endif
          end else begin
            fb_wr_en_reg   <= 1'b1;
            fb_wr_addr_reg <= sweep_addr;
            fb_wr_data_reg <= 1'b0;
          end
        end
`ifdef FB_SCHED_AXIS_EN
        AXIS: begin
          overrun_reg <= frame_pulse;
          if (sweep_done_reg) begin
            state_reg      <= PLOT;
            busy_reg       <= 1'b0;
            plot_ready_reg <= 1'b1;
          end else begin
            fb_wr_en_reg   <= 1'b1;
            fb_wr_addr_reg <= sweep_addr;
            fb_wr_data_reg <= 1'b1;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.plot_ready = plot_ready_reg;
  assign bus.fb_wr_en   = fb_wr_en_reg;
  assign bus.fb_wr_addr = fb_wr_addr_reg;
  assign bus.fb_wr_data = fb_wr_data_reg;
  assign busy           = busy_reg;
  assign frame_overrun  = overrun_reg;
endmodule

// File: tb/tb_framebuffer_write_scheduler.sv
// Bench for framebuffer_write_scheduler on an 8x4 screen: queue-based frame model
// checked every cycle, plus directed literal checks and a randomized phase.
module tb_framebuffer_write_scheduler;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  logic frame_pulse;
  logic busy;
  logic frame_overrun;

  always #5 clk = ~clk;

  fb_sched_if #(.ADDR_WIDTH(AW)) bus ();

  framebuffer_write_scheduler #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_pulse  (frame_pulse),
    .bus          (bus),
    .busy         (busy),
    .frame_overrun(frame_overrun)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of pending writes consumed one per cycle.
  typedef struct {
    int a;
    bit d;
  } wr_t;

  wr_t q[$];
  int  mode = 0;   // 0 idle, 1 sweeping, 2 plotter owns the port
  bit  pend = 0;
  bit  e_en = 0, e_data = 0, e_ready = 0, e_busy = 0, e_over = 0;
  int  e_addr = 0;

  function automatic void fill_frame();
    for (int i = 0; i < N; i++) q.push_back('{a: i, d: 1'b0});
`ifdef FB_SCHED_AXIS_EN
    for (int c = 0; c < W; c++) q.push_back('{a: (H / 2) * W + c, d: 1'b1});
`endif
  endfunction

  function automatic void issue_next();
    wr_t w;
    w      = q.pop_front();
    e_en   = 1'b1;
    e_addr = w.a;
    e_data = w.d;
    e_busy = 1'b1;
    mode   = 1;
  endfunction

  always @(posedge clk) begin : model
    bit beat;
    if (reset) begin
      q.delete();
      mode = 0; pend = 0;
      e_en = 0; e_addr = 0; e_data = 0; e_ready = 0; e_busy = 0; e_over = 0;
    end else begin
      beat = bus.plot_valid && e_ready;
      e_en = 0;
      e_over = 0;
      case (mode)
        0: if (frame_pulse) begin fill_frame(); issue_next(); end
        1: begin
          e_over = frame_pulse;
          if (q.size() == 0) begin
            mode = 2; e_busy = 0; e_ready = 1;
          end else begin
            issue_next();
          end
        end
        default: begin
          if (beat) begin
            e_en = 1; e_addr = int'(bus.plot_addr); e_data = bus.plot_data;
          end
          if (pend) begin
            pend = 0; fill_frame(); issue_next();
          end else if (frame_pulse) begin
            e_ready = 0;
            if (beat) pend = 1;
            else begin fill_frame(); issue_next(); end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("wr_en", 32'(bus.fb_wr_en), 32'(e_en));
      if (e_en) begin
        chk("wr_addr", 32'(bus.fb_wr_addr), 32'(e_addr));
        chk("wr_data", 32'(bus.fb_wr_data), 32'(e_data));
      end
      chk("plot_ready", 32'(bus.plot_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("overrun", 32'(frame_overrun), 32'(e_over));
    end
  end

  task automatic wait_ready(input int lim);
    int k = 0;
    while (!bus.plot_ready && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 32'(bus.plot_ready), 32'd1);
  endtask

  initial begin
    bit last_ready;
    int beats;
    reset = 1'b1; frame_pulse = 1'b0;
    bus.plot_valid = 1'b1; bus.plot_addr = 5'd3; bus.plot_data = 1'b1;
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_wr_en", 32'(bus.fb_wr_en), 0);
    chk("rst_wr_addr", 32'(bus.fb_wr_addr), 0);
    chk("rst_wr_data", 32'(bus.fb_wr_data), 0);
    chk("rst_ready", 32'(bus.plot_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(frame_overrun), 0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.plot_ready), 0);
      chk("idle_wr_en", 32'(bus.fb_wr_en), 0);
    end
    bus.plot_valid = 1'b0;

    // Full frame sweep timing
    frame_pulse = 1'b1;
    @(negedge clk);
    frame_pulse = 1'b0;
    chk("clr_first_addr", 32'(bus.fb_wr_addr), 0);
    chk("clr_first_en", 32'(bus.fb_wr_en), 1);
    chk("clr_first_ready", 32'(bus.plot_ready), 0);
    repeat (31) @(negedge clk);
    chk("clr_last_addr", 32'(bus.fb_wr_addr), 31);
    chk("clr_last_busy", 32'(busy), 1);
    @(negedge clk);
`ifdef FB_SCHED_AXIS_EN
    chk("axis_first_addr", 32'(bus.fb_wr_addr), 16);
    chk("axis_first_data", 32'(bus.fb_wr_data), 1);
    repeat (7) @(negedge clk);
    chk("axis_last_addr", 32'(bus.fb_wr_addr), 23);
    @(negedge clk);
`endif
    chk("plot_entry_ready", 32'(bus.plot_ready), 1);
    chk("plot_entry_busy", 32'(busy), 0);
    wait_ready(20);
    $display("frame 0: sweep finished, plotter granted at %0t", $time);

    // Plot beat, then back-to-back beats
    bus.plot_valid = 1'b1; bus.plot_addr = 5'd5; bus.plot_data = 1'b1;
    @(negedge clk);
    chk("beat_en", 32'(bus.fb_wr_en), 1);
    chk("beat_addr", 32'(bus.fb_wr_addr), 5);
    chk("beat_data", 32'(bus.fb_wr_data), 1);
    for (int i = 0; i < 6; i++) begin
      bus.plot_addr = AW'($urandom_range(0, N - 1));
      bus.plot_data = 1'($urandom_range(0, 1));
      $display("beat addr=%0d data=%0d", bus.plot_addr, bus.plot_data);
      @(negedge clk);
    end
    bus.plot_valid = 1'b0;

    // Overrun during clear
    frame_pulse = 1'b1;
    @(negedge clk);
    frame_pulse = 1'b0;
    repeat (9) @(negedge clk);
    chk("ovr_pre_addr", 32'(bus.fb_wr_addr), 9);
    frame_pulse = 1'b1;
    @(negedge clk);
    frame_pulse = 1'b0;
    chk("ovr_pulse", 32'(frame_overrun), 1);
    chk("ovr_addr", 32'(bus.fb_wr_addr), 10);
    @(negedge clk);
    chk("ovr_one_cycle", 32'(frame_overrun), 0);
    wait_ready(80);

    // Frame pulse together with an accepted beat
    frame_pulse = 1'b1;
    bus.plot_valid = 1'b1; bus.plot_addr = 5'd7; bus.plot_data = 1'b1;
    @(negedge clk);
    frame_pulse = 1'b0; bus.plot_valid = 1'b0;
    chk("coinc_addr", 32'(bus.fb_wr_addr), 7);
    chk("coinc_data", 32'(bus.fb_wr_data), 1);
    chk("coinc_ready", 32'(bus.plot_ready), 0);
    @(negedge clk);
    chk("coinc_clr_addr", 32'(bus.fb_wr_addr), 0);
    chk("coinc_clr_data", 32'(bus.fb_wr_data), 0);
    chk("coinc_clr_en", 32'(bus.fb_wr_en), 1);

    // Reset mid-sweep
    repeat (20) @(negedge clk);
    chk("mid_addr", 32'(bus.fb_wr_addr), 20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_en", 32'(bus.fb_wr_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("mid_idle_en", 32'(bus.fb_wr_en), 0);
    frame_pulse = 1'b1;
    @(negedge clk);
    frame_pulse = 1'b0;
    chk("restart_addr", 32'(bus.fb_wr_addr), 0);
    chk("restart_en", 32'(bus.fb_wr_en), 1);
    wait_ready(80);

    // Randomized traffic; the plotter holds a beat until it is accepted
    last_ready = 1'b0;
    beats = 0;
    for (int i = 0; i < 1500; i++) begin
      if (bus.plot_valid && last_ready) begin
        beats++;
        $display("rand beat %0d addr=%0d data=%0d", beats, bus.plot_addr, bus.plot_data);
      end
      if (!bus.plot_valid || last_ready) begin
        bus.plot_valid = ($urandom_range(0, 2) != 0);
        bus.plot_addr  = AW'($urandom_range(0, N - 1));
        bus.plot_data  = 1'($urandom_range(0, 1));
      end
      frame_pulse = ($urandom_range(0, 59) == 0);
      reset       = ($urandom_range(0, 399) == 0);
      last_ready  = bus.plot_ready && !reset;
      @(negedge clk);
    end
    reset = 1'b0; frame_pulse = 1'b0; bus.plot_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
